// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive and transmit paths.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 10417;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic [UART_DATA_BITS-1:0]          push_data,
  input  logic                               pop,
  output logic [UART_DATA_BITS-1:0]          pop_data,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [CNT_W-1:0]          count_q;
  logic                      push_ok;
  logic                      pop_ok;

  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    empty    = (count_q == '0);
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    count    = count_q;
    pop_data = empty ? '0 : mem[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the read side is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: synchroniser, mid-bit sampling FSM, sticky error flags
// and a FWFT byte FIFO read through a valid/ready pop port.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic                            uart_rxd,
  output logic [UART_DATA_BITS-1:0]       rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic                            rx_overrun,
  output logic                            rx_frame_err,
  input  logic                            err_clear,
  output logic                            dbg_rx_active,
  output logic                            dbg_rx_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);

  // Terminal counts: START waits half a bit, DATA/STOP wait a full bit.
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'((CLKS_PER_BIT - 1) / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

  logic [1:0]                sync_q;
  logic                      rxd_s;
  rx_state_t                 state_q;
  logic [BAUD_W-1:0]         baud_q;
  logic [BIT_W-1:0]          bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      push_q;
  logic                      ferr_ev_q;
  logic                      done_q;
  logic                      overrun_q;
  logic                      frame_err_q;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      overrun_ev;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) sync_q <= 2'b11;
    else              sync_q <= {sync_q[0], uart_rxd};
  end

  assign rxd_s = sync_q[1];

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      ferr_ev_q <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      ferr_ev_q <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (!rxd_s) state_q <= START;
        end
        START: begin
          if (baud_q == HALF_LAST) begin
            baud_q <= '0;
            if (rxd_s) begin
              state_q <= IDLE;
            end else begin
              bit_q   <= '0;
              state_q <= DATA;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_q == FULL_LAST) begin
            baud_q  <= '0;
            shift_q <= {rxd_s, shift_q[UART_DATA_BITS-1:1]};
            if (bit_q == LAST_BIT) state_q <= STOP;
            else                   bit_q   <= bit_q + BIT_W'(1);
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_q == FULL_LAST) begin
            baud_q <= '0;
            if (rxd_s) begin
              push_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_ev_q <= 1'b1;
              state_q   <= BREAK;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        BREAK: begin
          if (rxd_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A full FIFO still takes the byte when the head is popped in the same cycle.
  assign overrun_ev = push_q && fifo_full && !rx_ready;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_q <= push_q;
      if (overrun_ev)     overrun_q <= 1'b1;
      else if (err_clear) overrun_q <= 1'b0;
      if (ferr_ev_q)      frame_err_q <= 1'b1;
      else if (err_clear) frame_err_q <= 1'b0;
    end
  end

  uart_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (S_AXI_ACLK),
    .rst       (S_AXI_ARESET),
    .push      (push_q),
    .push_data (shift_q),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rx_count)
  );

  assign rx_valid      = !fifo_empty;
  assign rx_overrun    = overrun_q;
  assign rx_frame_err  = frame_err_q;
  assign dbg_rx_done   = done_q;
  assign dbg_rx_active = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame-level reference model (byte queue plus
// scheduled frame-end events) compared every cycle, plus directed literals.
module tb_uart_rx_core;

  localparam int unsigned C   = 16;
  localparam int unsigned D   = 4;
  localparam int unsigned LAT = 2 + (C - 1) / 2 + 9 * C + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       dbg_rx_active;
  logic       dbg_rx_done;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .uart_rxd      (rxd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_count      (rx_count),
    .rx_overrun    (rx_overrun),
    .rx_frame_err  (rx_frame_err),
    .err_clear     (err_clear),
    .dbg_rx_active (dbg_rx_active),
    .dbg_rx_done   (dbg_rx_done)
  );

  typedef struct {
    int         at_edge;
    logic [7:0] data;
    bit         ok;
  } ev_t;

  ev_t        pend[$];
  logic [7:0] mq[$];
  bit         m_ovr = 0, m_ferr = 0, m_done = 0;
  int         ecount = 0;
  int         n_cmp = 0, n_err = 0;
  int         cur_t0 = 0, push_edge = 0;
  int         ready_mode = 0;
  int         rise_edge = -1, done_cnt = 0;
  logic       prev_valid = 1'b0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h, want %0h", name, ecount, got, exp);
    end
  endtask

  // Reference model: each frame end lands LAT edges after its start edge.
  always @(posedge clk) begin
    ecount++;
    if (rst) begin
      mq.delete();
      pend.delete();
      m_ovr  = 0;
      m_ferr = 0;
      m_done = 0;
    end else begin : mdl
      bit  was_full, popped, new_ovr, new_ferr;
      ev_t e;
      was_full = (mq.size() == D);
      popped   = rx_ready && (mq.size() > 0);
      if (popped) void'(mq.pop_front());
      m_done   = 0;
      new_ovr  = 0;
      new_ferr = 0;
      while (pend.size() > 0 && pend[0].at_edge == ecount) begin
        e = pend.pop_front();
        if (e.ok) begin
          m_done = 1;
          if (!was_full || popped) mq.push_back(e.data);
          else new_ovr = 1;
        end else begin
          new_ferr = 1;
        end
      end
      if (new_ovr) m_ovr = 1;
      else if (err_clear) m_ovr = 0;
      if (new_ferr) m_ferr = 1;
      else if (err_clear) m_ferr = 0;
    end
  end

  always @(negedge clk) begin : cmp
    logic [7:0] exp_data;
    exp_data = 8'h00;
    if (mq.size() > 0) exp_data = mq[0];
    chk("rx_valid", {31'b0, rx_valid}, {31'b0, mq.size() != 0});
    chk("rx_data", {24'b0, rx_data}, {24'b0, exp_data});
    chk("rx_count", {29'b0, rx_count}, mq.size());
    chk("rx_overrun", {31'b0, rx_overrun}, {31'b0, m_ovr});
    chk("rx_frame_err", {31'b0, rx_frame_err}, {31'b0, m_ferr});
    chk("dbg_rx_done", {31'b0, dbg_rx_done}, {31'b0, m_done});
  end

  always @(negedge clk) begin
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_edge = ecount;
    if (dbg_rx_done === 1'b1) done_cnt++;
    prev_valid = rx_valid;
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      case (ready_mode)
        1:       rx_ready = 1'b1;
        2:       rx_ready = ($urandom_range(0, 3) == 0);
        3:       rx_ready = (ecount + 1 == push_edge);
        default: rx_ready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  task automatic pop_one();
    ready_mode = 1;
    tick();
    ready_mode = 0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  // abort_after >= 0 stops driving after that data bit (frame never completes).
  task automatic send_frame(logic [7:0] b, bit stop_ok, int abort_after);
    ev_t e;
    rxd       = 1'b0;
    cur_t0    = ecount + 1;
    push_edge = cur_t0 + LAT;
    e.at_edge = push_edge;
    e.data    = b;
    e.ok      = stop_ok;
    pend.push_back(e);
    repeat (C) tick();
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (C) tick();
      if (k == abort_after) return;
    end
    rxd = stop_ok;
    repeat (C) tick();
  endtask

  initial begin : main
    int g0, d0;
    logic [7:0] b;
    bit ok;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("reset_valid", {31'b0, rx_valid}, 0);
    chk("reset_count", {29'b0, rx_count}, 0);
    chk("reset_active", {31'b0, dbg_rx_active}, 0);
    rst = 1'b0;
    idle(4);

    // Single frame 0xA5
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1, -1);
    idle(4);
    chk("a5_rise_edge", rise_edge, cur_t0 + 154);
    chk("a5_data", {24'b0, rx_data}, 32'hA5);
    chk("a5_count", {29'b0, rx_count}, 1);
    chk("a5_done_pulses", done_cnt - d0, 1);
    pop_one();
    chk("a5_popped_valid", {31'b0, rx_valid}, 0);

    // Glitch of three cycles
    rxd = 1'b0;
    g0  = ecount + 1;
    repeat (3) tick();
    rxd = 1'b1;
    chk("glitch_active_start", {31'b0, dbg_rx_active}, 1);
    while (ecount < g0 + 12) tick();
    chk("glitch_active_idle", {31'b0, dbg_rx_active}, 0);
    chk("glitch_count", {29'b0, rx_count}, 0);
    idle(C);

    // Framing error followed by a held-low break
    send_frame(8'h3C, 1'b0, -1);
    rxd = 1'b0;
    repeat (40) tick();
    chk("ferr_flag", {31'b0, rx_frame_err}, 1);
    chk("ferr_count", {29'b0, rx_count}, 0);
    chk("ferr_in_break", {31'b0, dbg_rx_active}, 1);
    rxd = 1'b1;
    repeat (4) tick();
    chk("ferr_break_exit", {31'b0, dbg_rx_active}, 0);
    pulse_clear();
    chk("ferr_cleared", {31'b0, rx_frame_err}, 0);
    idle(C);

    // Overrun: five frames, no pops
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1);
    idle(4);
    chk("ovr_count", {29'b0, rx_count}, 4);
    chk("ovr_flag", {31'b0, rx_overrun}, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_pop_data", {24'b0, rx_data}, i);
      pop_one();
    end
    chk("ovr_drained", {31'b0, rx_valid}, 0);
    pulse_clear();
    chk("ovr_cleared", {31'b0, rx_overrun}, 0);

    // Full FIFO with a pop on the fifth push edge
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, -1);
    ready_mode = 3;
    send_frame(8'h15, 1'b1, -1);
    ready_mode = 0;
    idle(4);
    chk("fullpop_overrun", {31'b0, rx_overrun}, 0);
    chk("fullpop_count", {29'b0, rx_count}, 4);
    chk("fullpop_head", {24'b0, rx_data}, 32'h12);

    // Reset mid-DATA after bit 3
    send_frame(8'hC3, 1'b1, 3);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) tick();
    chk("rst_valid", {31'b0, rx_valid}, 0);
    chk("rst_data", {24'b0, rx_data}, 0);
    chk("rst_count", {29'b0, rx_count}, 0);
    chk("rst_active", {31'b0, dbg_rx_active}, 0);
    rst = 1'b0;
    idle(C);
    send_frame(8'h5A, 1'b1, -1);
    idle(4);
    chk("post_rst_data", {24'b0, rx_data}, 32'h5A);
    chk("post_rst_count", {29'b0, rx_count}, 1);
    pop_one();

    // Randomized traffic with random pops
    ready_mode = 2;
    for (int f = 0; f < 24; f++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 6) != 0);
      send_frame(b, ok, -1);
      if (!ok) begin
        rxd = 1'b0;
        repeat ($urandom_range(0, 30)) tick();
        idle(C);
      end
      idle($urandom_range(0, 2) * C + $urandom_range(0, C - 1));
      if ($urandom_range(0, 4) == 0) pulse_clear();
    end
    idle(200);
    ready_mode = 1;
    idle(20);
    ready_mode = 0;
    tick();
    chk("final_drained", {31'b0, rx_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
